// File: rtl/priority_display_pkg.sv
// Shared types and constants for the priority display scheduler.
// Optional build macro PRIORITY_DISPLAY_ROUND_ROBIN_EN selects round-robin arbitration.
package priority_display_pkg;

    localparam int unsigned NUM_REQ = 8;
    localparam int unsigned IDX_W   = 3;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t GRANT = 2'd1;
    localparam state_t GAP   = 2'd2;

    // Segment codes, bit order gfedcba, active high
    localparam logic [6:0] SEG_DIGIT_0 = 7'b0111111;
    localparam logic [6:0] SEG_DIGIT_1 = 7'b0000110;
    localparam logic [6:0] SEG_DIGIT_2 = 7'b1011011;
    localparam logic [6:0] SEG_DIGIT_3 = 7'b1001111;
    localparam logic [6:0] SEG_DIGIT_4 = 7'b1100110;
    localparam logic [6:0] SEG_DIGIT_5 = 7'b1101101;
    localparam logic [6:0] SEG_DIGIT_6 = 7'b1111101;
    localparam logic [6:0] SEG_DIGIT_7 = 7'b0000111;
    localparam logic [6:0] SEG_BLANK   = 7'b0000000;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational 3-bit index to 7-segment (gfedcba) decoder.
module seg7_decoder
    import priority_display_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    output logic [6:0]       seg
);

    always_comb begin
        seg = SEG_BLANK;
        unique case (idx)
            3'd0: seg = SEG_DIGIT_0;
            3'd1: seg = SEG_DIGIT_1;
            3'd2: seg = SEG_DIGIT_2;
            3'd3: seg = SEG_DIGIT_3;
            3'd4: seg = SEG_DIGIT_4;
            3'd5: seg = SEG_DIGIT_5;
            3'd6: seg = SEG_DIGIT_6;
            3'd7: seg = SEG_DIGIT_7;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/priority_display_scheduler.sv
// Shares one 7-segment display among 8 requesters with bounded grants and blanking gaps.
// Define PRIORITY_DISPLAY_ROUND_ROBIN_EN for round-robin instead of fixed priority.
module priority_display_scheduler
    import priority_display_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 10_000_000,
    parameter int unsigned GAP_CYCLES  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid,
    output logic [6:0]         segments,
    output logic               no_data
);

    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned GAP_W  = $clog2(GAP_CYCLES + 1);

    logic [NUM_REQ-1:0] req_m, req_s;
    state_t             state;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [IDX_W-1:0]   win;
    logic [6:0]         win_seg;

`ifdef PRIORITY_DISPLAY_ROUND_ROBIN_EN
    logic [IDX_W-1:0] rr_ptr;

    // Descending search from rr_ptr-1; k == NUM_REQ wraps to rr_ptr itself (last choice)
    always_comb begin
        logic [IDX_W-1:0] cand;
        cand = '0;
        win  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = rr_ptr - IDX_W'(k);
            if (req_s[cand]) win = cand;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (state == IDLE && |req_s) begin
            rr_ptr <= win;
        end
    end
`else
    always_comb begin
        win = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_s[i]) win = IDX_W'(i);
        end
    end
`endif

    seg7_decoder u_seg7_decoder (
        .idx (win),
        .seg (win_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_m       <= '0;
            req_s       <= '0;
            state       <= IDLE;
            hold_cnt    <= '0;
            gap_cnt     <= '0;
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            segments    <= SEG_BLANK;
            no_data     <= 1'b1;
        end else begin
            req_m <= req;
            req_s <= req_m;
            case (state)
                IDLE: begin
                    if (|req_s) begin
                        state       <= GRANT;
                        hold_cnt    <= HOLD_W'(HOLD_CYCLES - 1);
                        grant       <= NUM_REQ'(1) << win;
                        grant_idx   <= win;
                        grant_valid <= 1'b1;
                        segments    <= win_seg;
                        no_data     <= 1'b0;
                    end
                end
                GRANT: begin
                    if (hold_cnt == '0 || !req_s[grant_idx]) begin
                        state       <= GAP;
                        gap_cnt     <= GAP_W'(GAP_CYCLES - 1);
                        grant       <= '0;
                        grant_idx   <= '0;
                        grant_valid <= 1'b0;
                        segments    <= SEG_BLANK;
                        no_data     <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_priority_display_scheduler.sv
// Self-checking bench: vector table, directed corner sequences and a randomized reference model.
module tb_priority_display_scheduler;

    localparam int HOLD = 4;
    localparam int GAPC = 1;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic [6:0] segments;
    logic       no_data;

    int n_vec;
    int n_bad;

    priority_display_scheduler #(
        .HOLD_CYCLES (HOLD),
        .GAP_CYCLES  (GAPC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .segments    (segments),
        .no_data     (no_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] seg_tab [8];

    // Reference model: current owner (-1 none), cycles granted so far, blank cycles left
    int         cur;
    int         used;
    int         cool;
    int         last;
    logic [7:0] h1, h2;

    function automatic int pick(input logic [7:0] rs, input int lst);
`ifdef PRIORITY_DISPLAY_ROUND_ROBIN_EN
        for (int k = 1; k <= 8; k++) begin
            int i;
            i = (lst - k + 16) % 8;
            if (rs[i]) return i;
        end
`else
        for (int i = 7; i >= 0; i--) begin
            if (rs[i]) return i;
        end
`endif
        return -1;
    endfunction

    task automatic model_reset();
        cur  = -1;
        used = 0;
        cool = 0;
        last = 0;
        h1   = 8'h00;
        h2   = 8'h00;
    endtask

    task automatic model_edge();
        logic [7:0] rs;
        if (!rst_n) begin
            model_reset();
        end else begin
            rs = h2;
            h2 = h1;
            h1 = req;
            if (cur >= 0) begin
                if (used >= HOLD || !rs[cur]) begin
                    cur  = -1;
                    cool = GAPC;
                end else begin
                    used++;
                end
            end else if (cool > 0) begin
                cool--;
            end else if (rs != 8'h00) begin
                cur  = pick(rs, last);
                last = cur;
                used = 1;
            end
        end
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %02h, expected %02h", name, $time, act, exp);
        end
    endtask

    task automatic check_all();
        logic [7:0] eg;
        eg = (cur >= 0) ? (8'h01 << cur) : 8'h00;
        check("grant", grant, eg);
        check("grant_idx", {5'd0, grant_idx}, (cur >= 0) ? 8'(cur) : 8'h00);
        check("grant_valid", {7'd0, grant_valid}, {7'd0, cur >= 0});
        check("segments", {1'b0, segments}, (cur >= 0) ? {1'b0, seg_tab[cur]} : 8'h00);
        check("no_data", {7'd0, no_data}, {7'd0, cur < 0});
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic do_reset(input logic [7:0] r);
        rst_n = 1'b0;
        req   = r;
        #1;
        model_reset();
        step();
        step();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [7:0] req;
        int         exp_idx;
        logic [6:0] exp_seg;
    } vec_t;

    vec_t tbl [9];

    initial begin
        n_vec = 0;
        n_bad = 0;
        seg_tab[0] = 7'b0111111; seg_tab[1] = 7'b0000110;
        seg_tab[2] = 7'b1011011; seg_tab[3] = 7'b1001111;
        seg_tab[4] = 7'b1100110; seg_tab[5] = 7'b1101101;
        seg_tab[6] = 7'b1111101; seg_tab[7] = 7'b0000111;

        tbl[0] = '{8'h01, 0, 7'b0111111};
        tbl[1] = '{8'h03, 1, 7'b0000110};
        tbl[2] = '{8'h04, 2, 7'b1011011};
        tbl[3] = '{8'h0C, 3, 7'b1001111};
        tbl[4] = '{8'h1F, 4, 7'b1100110};
        tbl[5] = '{8'h24, 5, 7'b1101101};
        tbl[6] = '{8'h55, 6, 7'b1111101};
        tbl[7] = '{8'hFF, 7, 7'b0000111};
        tbl[8] = '{8'h90, 7, 7'b0000111};

        rst_n = 1'b1;
        req   = 8'h00;
        model_reset();

        // Reset with all requests held, then first grant on the third edge
        do_reset(8'hFF);
        check("rst_grant", grant, 8'h00);
        check("rst_no_data", {7'd0, no_data}, 8'h01);
        step();
        step();
        check("pre_grant", grant, 8'h00);
        step();
        check("first_grant", grant, 8'h80);

        // First arbitration after reset from each table pattern
        for (int v = 0; v < 9; v++) begin
            do_reset(tbl[v].req);
            step();
            step();
            step();
            check("tbl_grant", grant, 8'h01 << tbl[v].exp_idx);
            check("tbl_idx", {5'd0, grant_idx}, 8'(tbl[v].exp_idx));
            check("tbl_seg", {1'b0, segments}, {1'b0, tbl[v].exp_seg});
        end

        // Hold exactly HOLD cycles, one GAP, one IDLE, then re-grant
        do_reset(8'h24);
        step();
        step();
        for (int c = 0; c < HOLD; c++) begin
            step();
            check("hold_grant", grant, 8'h20);
        end
        step();
        check("gap_blank", grant, 8'h00);
        step();
        check("idle_blank", {7'd0, no_data}, 8'h01);
        step();
`ifdef PRIORITY_DISPLAY_ROUND_ROBIN_EN
        check("regrant", grant, 8'h04);
`else
        check("regrant", grant, 8'h20);
`endif

        // Early release: drop after one granted cycle, clears three edges later
        do_reset(8'h01);
        step();
        step();
        step();
        check("early_seg", {1'b0, segments}, 8'h3F);
        req = 8'h00;
        step();
        step();
        check("early_still", grant, 8'h01);
        step();
        check("early_clear", grant, 8'h00);

        // Asynchronous reset in the middle of a grant
        do_reset(8'h10);
        step();
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_grant", grant, 8'h00);
        check("async_valid", {7'd0, grant_valid}, 8'h00);
        check_all();
        step();
        rst_n = 1'b1;
        step();
        step();
        check("restart_wait", grant, 8'h00);
        step();
        check("restart_grant", grant, 8'h10);

        // Release coinciding with expiry, and no preemption by a later higher request
        do_reset(8'h08);
        step();
        step();
        step();
        req = 8'h88;
        step();
        req = 8'h80;
        step();
        step();
        check("coinc_last", grant, 8'h08);
        step();
        check("coinc_exit", grant, 8'h00);
        step();
        check("coinc_idle", grant, 8'h00);
        step();
        check("coinc_next", grant, 8'h80);

`ifdef PRIORITY_DISPLAY_ROUND_ROBIN_EN
        // Round-robin rotation with every requester held
        do_reset(8'hFF);
        step();
        step();
        for (int g = 0; g < 9; g++) begin
            step();
            check("rr_seq", grant, 8'h01 << ((7 - g + 8) % 8));
            for (int c = 1; c < HOLD + GAPC + 1 + 1; c++) step();
        end
`endif

        // Randomized traffic against the reference model
        do_reset(8'h00);
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 5) == 0) req = 8'($urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
